// File: rtl/rggen_native_posted_adapter.sv
// Native CSR front end: a FIFO request queue with posted writes, a downstream timeout watchdog
// and a sticky error flag for posted writes that fail or time out.
module rggen_native_posted_adapter #(
  parameter int                   ADDRESS_WIDTH      = 8,
  parameter int                   BUS_WIDTH          = 32,
  parameter int                   STROBE_WIDTH       = BUS_WIDTH / 8,
  parameter int                   WRITE_BUFFER_DEPTH = 2,
  parameter int                   TIMEOUT_CYCLES     = 0,
  parameter logic [1:0]           TIMEOUT_STATUS     = 2'b10,
  parameter logic [BUS_WIDTH-1:0] DEFAULT_READ_DATA  = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_csr_valid,
  input  logic [1:0]               i_csr_access,
  input  logic [ADDRESS_WIDTH-1:0] i_csr_address,
  input  logic [BUS_WIDTH-1:0]     i_csr_write_data,
  input  logic [STROBE_WIDTH-1:0]  i_csr_strobe,
  output logic                     o_csr_ready,
  output logic [1:0]               o_csr_status,
  output logic [BUS_WIDTH-1:0]     o_csr_read_data,
  output logic                     o_bus_valid,
  output logic [1:0]               o_bus_access,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]     o_bus_write_data,
  output logic [STROBE_WIDTH-1:0]  o_bus_strobe,
  input  logic                     i_bus_ready,
  input  logic [1:0]               i_bus_status,
  input  logic [BUS_WIDTH-1:0]     i_bus_read_data,
  input  logic                     i_error_clear,
  output logic                     o_write_error
);
  localparam int DEPTH       = (WRITE_BUFFER_DEPTH > 0) ? WRITE_BUFFER_DEPTH : 1;
  localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);
  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LIMIT =
    TIMER_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0]   PTR_LAST   = PTR_WIDTH'(DEPTH - 1);

  logic [1:0]               access_mem  [DEPTH];
  logic [ADDRESS_WIDTH-1:0] address_mem [DEPTH];
  logic [BUS_WIDTH-1:0]     data_mem    [DEPTH];
  logic [STROBE_WIDTH-1:0]  strobe_mem  [DEPTH];
  logic                     resp_mem    [DEPTH];

  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [COUNT_WIDTH-1:0] count;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   wait_resp;
  logic                   empty;
  logic                   full;
  logic                   push;
  logic                   push_resp;
  logic                   pop;
  logic                   timeout_hit;
  logic                   head_resp;
  logic                   write_error_set;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == COUNT_FULL);
  assign push      = i_csr_valid && !o_csr_ready && !wait_resp && !full;
  assign push_resp = !(i_csr_access[0] && (WRITE_BUFFER_DEPTH > 0));
  assign head_resp = resp_mem[rd_ptr];

  // Ready arriving in the limit cycle is a normal completion, not an abort.
  assign timeout_hit     = (TIMEOUT_CYCLES > 0) && !empty && !i_bus_ready && (timer == TIMER_LIMIT);
  assign pop             = !empty && (i_bus_ready || timeout_hit);
  assign write_error_set = pop && !head_resp && (timeout_hit || i_bus_status[1]);

  assign o_bus_valid      = !empty;
  assign o_bus_access     = access_mem[rd_ptr];
  assign o_bus_address    = address_mem[rd_ptr];
  assign o_bus_write_data = data_mem[rd_ptr];
  assign o_bus_strobe     = strobe_mem[rd_ptr];

  // Payload storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      access_mem[wr_ptr]  <= i_csr_access;
      address_mem[wr_ptr] <= i_csr_address;
      data_mem[wr_ptr]    <= i_csr_write_data;
      strobe_mem[wr_ptr]  <= i_csr_strobe;
      resp_mem[wr_ptr]    <= push_resp;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      timer           <= '0;
      wait_resp       <= 1'b0;
      o_csr_ready     <= 1'b0;
      o_csr_status    <= 2'b00;
      o_csr_read_data <= '0;
      o_write_error   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + COUNT_WIDTH'(1);
      end else if (!push && pop) begin
        count <= count - COUNT_WIDTH'(1);
      end

      if (pop) begin
        timer <= '0;
      end else if ((TIMEOUT_CYCLES > 0) && !empty && !i_bus_ready) begin
        timer <= timer + TIMER_WIDTH'(1);
      end

      // A resp entry at the head implies wait_resp, so push and resp completion never collide.
      o_csr_ready <= 1'b0;
      if (push && !push_resp) begin
        o_csr_ready     <= 1'b1;
        o_csr_status    <= 2'b00;
        o_csr_read_data <= '0;
      end else if (pop && head_resp) begin
        o_csr_ready     <= 1'b1;
        o_csr_status    <= i_bus_ready ? i_bus_status : TIMEOUT_STATUS;
        o_csr_read_data <= i_bus_ready ? i_bus_read_data : DEFAULT_READ_DATA;
        wait_resp       <= 1'b0;
      end
      if (push && push_resp) begin
        wait_resp <= 1'b1;
      end

      if (write_error_set) begin
        o_write_error <= 1'b1;
      end else if (i_error_clear) begin
        o_write_error <= 1'b0;
      end
    end
  end
endmodule
